// File: rtl/scalar_alu_arbiter.sv
// Round-robin arbiter sharing one combinational scalar ALU between the scalar
// issue path (requester 0) and the vector AGU (requester 1), with a one-entry tagged response buffer.
module scalar_alu_arbiter #(
   parameter int LEN       = 32,
   parameter int ALU_SIG_W = 3,
   parameter int FUNC_W    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [LEN-1:0]       req0_rs1,
   input  logic [LEN-1:0]       req0_rs2,
   input  logic [LEN-1:0]       req0_imm,
   input  logic [LEN-1:0]       req0_pc,
   input  logic [ALU_SIG_W-1:0] req0_alu_signal,
   input  logic [FUNC_W-1:0]    req0_func_code,
   input  logic [LEN-1:0]       req1_rs1,
   input  logic [LEN-1:0]       req1_rs2,
   input  logic [LEN-1:0]       req1_imm,
   input  logic [LEN-1:0]       req1_pc,
   input  logic [ALU_SIG_W-1:0] req1_alu_signal,
   input  logic [FUNC_W-1:0]    req1_func_code,
   output logic [LEN-1:0]       alu_rs1,
   output logic [LEN-1:0]       alu_rs2,
   output logic [LEN-1:0]       alu_imm,
   output logic [LEN-1:0]       alu_pc,
   output logic [ALU_SIG_W-1:0] alu_signal,
   output logic [FUNC_W-1:0]    alu_func_code,
   input  logic [LEN-1:0]       alu_result,
   input  logic [1:0]           alu_sign_bits,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [LEN-1:0]       rsp_result,
   output logic [1:0]           rsp_sign_bits
);

   localparam logic [ALU_SIG_W-1:0] ALU_NOP = '0;

   logic           r_rsp_valid;
   logic           r_rsp_id;
   logic           r_rr_ptr;
   logic [LEN-1:0] r_rsp_result;
   logic [1:0]     r_rsp_sign;

   logic w_buf_free;
   logic w_gnt;
   logic w_gnt_id;

   // rst_n gates the grant so req_ready stays low for the whole reset window
   assign w_buf_free = !r_rsp_valid || rsp_ready;
   assign w_gnt      = rst_n && !flush && w_buf_free && (req_valid != 2'b00);
   assign w_gnt_id   = (req_valid == 2'b11) ? r_rr_ptr : req_valid[1];
   assign req_ready  = w_gnt ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;

   // Idle cycles must present a NOP so the ALU stays quiet
   always_comb begin
      alu_rs1       = '0;
      alu_rs2       = '0;
      alu_imm       = '0;
      alu_pc        = '0;
      alu_signal    = ALU_NOP;
      alu_func_code = '0;
      if (w_gnt) begin
         if (w_gnt_id) begin
            alu_rs1       = req1_rs1;
            alu_rs2       = req1_rs2;
            alu_imm       = req1_imm;
            alu_pc        = req1_pc;
            alu_signal    = req1_alu_signal;
            alu_func_code = req1_func_code;
         end else begin
            alu_rs1       = req0_rs1;
            alu_rs2       = req0_rs2;
            alu_imm       = req0_imm;
            alu_pc        = req0_pc;
            alu_signal    = req0_alu_signal;
            alu_func_code = req0_func_code;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_sign   <= 2'b00;
         r_rr_ptr     <= 1'b0;
      end else if (flush) begin
         r_rsp_valid <= 1'b0;
      end else if (w_gnt) begin
         r_rsp_valid  <= 1'b1;
         r_rsp_id     <= w_gnt_id;
         r_rsp_result <= alu_result;
         r_rsp_sign   <= alu_sign_bits;
         r_rr_ptr     <= ~w_gnt_id;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid     = r_rsp_valid;
   assign rsp_id        = r_rsp_id;
   assign rsp_result    = r_rsp_result;
   assign rsp_sign_bits = r_rsp_sign;

endmodule
